// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one uart_tx byte stream between
// NumReq requesters; a grant ends on a last-flagged byte or after MaxBurst bytes.
module uart_tx_arbiter #(
    parameter  int NumReq   = 4,
    parameter  int MaxBurst = 16,
    localparam int GrantW   = $clog2(NumReq)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumReq-1:0]   req_valid_i,
    input  logic [NumReq-1:0]   req_last_i,
    input  logic [NumReq*8-1:0] req_data_i,
    output logic [NumReq-1:0]   req_ready_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [7:0]          data_o,
    output logic                busy_o,
    output logic [GrantW-1:0]   grant_o
);

    // Handshake: a byte moves on any cycle where valid_o && ready_i; upstream,
    // requester n moves a byte when req_valid_i[n] && req_ready_o[n]. Only the
    // granted requester ever sees ready, and ready never depends on valid.

    localparam int CntW = (MaxBurst == 0) ? 1 : $clog2(MaxBurst + 1);
    localparam logic [CntW-1:0]   BurstLast = (MaxBurst == 0) ? '0 : CntW'(MaxBurst - 1);
    localparam logic [GrantW-1:0] RrInit    = GrantW'(NumReq - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [GrantW-1:0] grant_q, grant_d;
    logic [GrantW-1:0] rr_q, rr_d;
    logic [CntW-1:0]   count_q, count_d;

    logic [GrantW-1:0] sel;
    logic              any_req;
    int                scan_pos;
    logic [GrantW-1:0] scan_idx;
    logic [7:0]        req_bytes [NumReq];
    logic              xfer;
    logic              release_grant;

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            req_bytes[i] = req_data_i[i*8 +: 8];
        end
    end

    // Scan from the farthest offset down so the nearest valid requester after
    // rr_q is the last assignment and therefore wins.
    always_comb begin
        sel      = '0;
        any_req  = 1'b0;
        scan_pos = 0;
        scan_idx = '0;
        for (int off = NumReq; off >= 1; off--) begin
            scan_pos = (int'(rr_q) + off) % NumReq;
            scan_idx = scan_pos[GrantW-1:0];
            if (req_valid_i[scan_idx]) begin
                sel     = scan_idx;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        valid_o     = 1'b0;
        data_o      = 8'h00;
        req_ready_o = '0;
        if (state_q == ST_LOCKED && !rst_i) begin
            valid_o              = req_valid_i[grant_q];
            data_o               = req_bytes[grant_q];
            req_ready_o[grant_q] = ready_i;
        end
    end

    assign xfer          = valid_o && ready_i;
    assign release_grant = req_last_i[grant_q] || ((MaxBurst != 0) && (count_q == BurstLast));
    assign busy_o        = (state_q == ST_LOCKED);
    assign grant_o       = grant_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d = sel;
                    rr_d    = sel;
                    count_d = '0;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                // A stalled requester keeps the grant; only a transfer can end it.
                if (xfer) begin
                    if (release_grant) begin
                        state_d = ST_IDLE;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CntW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= RrInit;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            count_q <= count_d;
        end
    end

endmodule
